// File: rtl/fm_pkg.sv
// Shared types and helpers for the FM demodulator and transmit-side blocks.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package fm_pkg;

    // Default phase word width; 2^DEFAULT_PHASE_WIDTH corresponds to 2*pi.
    localparam int DEFAULT_PHASE_WIDTH = 16;

    // Demodulator sequencing: PRIME holds the first phase, RUN differences.
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } demod_state_t;

    // Clip a wide signed value into the signed range of an out_w-bit word.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                    input int               out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/fm_demodulator_sat_shift.sv
// Arithmetic left shift with saturation to a narrower signed output.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
module sat_shift
    import fm_pkg::*;
#(
    parameter int IN_W  = 31,
    parameter int OUT_W = 16,
    parameter int SH_W  = 5
) (
    input  logic signed [IN_W-1:0]  din,
    input  logic        [SH_W-1:0]  shift,
    output logic signed [OUT_W-1:0] dout
);

    // IN_W + 2^SH_W - 1 must stay within 63 bits so the shift never overflows.
    logic signed [63:0] wide;
    logic signed [63:0] clipped;

    // Shift in a 64-bit signed domain, then clip to the output range.
    always_comb begin
        wide    = 64'(din) <<< shift;
        clipped = sat_clip(wide, OUT_W);
        dout    = OUT_W'(clipped);
    end

endmodule

// File: rtl/fm_demodulator.sv
// FM discriminator: wrapped phase differencing, 2^k averaging, saturating gain.
// Latency: output valid one cycle after the handshake of a window's last sample.
// Backpressure: one-deep output register; input stalls while it is full and not accepted.
module fm_demodulator
    import fm_pkg::*;
#(
    parameter int PHASE_WIDTH        = DEFAULT_PHASE_WIDTH,
    parameter int M_AXIS_TDATA_WIDTH = 16,
    parameter int ACC_WIDTH          = PHASE_WIDTH + 15
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 demod_enable,
    input  logic        [3:0]                    log2_avg,
    input  logic        [4:0]                    shift_gain,
    input  logic                                 S_AXIS_tvalid,
    input  logic signed [PHASE_WIDTH-1:0]        S_AXIS_tdata,
    output logic                                 S_AXIS_tready,
    input  logic                                 M_AXIS_tready,
    output logic                                 M_AXIS_tvalid,
    output logic signed [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

    localparam int CNT_W = 16;

    demod_state_t                          state;
    logic signed [PHASE_WIDTH-1:0]         prev;
    logic signed [PHASE_WIDTH-1:0]         delta;
    logic signed [ACC_WIDTH-1:0]           acc;
    logic signed [ACC_WIDTH-1:0]           sum;
    logic signed [ACC_WIDTH-1:0]           avg;
    logic        [CNT_W-1:0]               cnt;
    logic        [CNT_W-1:0]               cnt_last;
    logic        [3:0]                     avg_q;
    logic        [3:0]                     cur_log2;
    logic                                  hs;
    logic                                  last;
    logic signed [M_AXIS_TDATA_WIDTH-1:0]  gained;

    // Disabled: swallow input so upstream never stalls; otherwise only the output register gates.
    assign S_AXIS_tready = !demod_enable || !M_AXIS_tvalid || M_AXIS_tready;
    assign hs            = S_AXIS_tvalid && S_AXIS_tready;

    // Phase delta with natural modulo wrap, and the averaging datapath for the current window.
    always_comb begin
        delta    = S_AXIS_tdata - prev;
        // The first delta of a window uses the live setting; later ones use the latched copy.
        cur_log2 = (cnt == '0) ? log2_avg : avg_q;
        cnt_last = CNT_W'((32'd1 << cur_log2) - 32'd1);
        last     = (cnt == cnt_last);
        sum      = acc + ACC_WIDTH'(delta);
        avg      = sum >>> cur_log2;
    end

    sat_shift #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (M_AXIS_TDATA_WIDTH),
        .SH_W  (5)
    ) u_sat_shift (
        .din   (avg),
        .shift (shift_gain),
        .dout  (gained)
    );

    // Sequencer, accumulator and output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= PRIME;
            prev          <= '0;
            acc           <= '0;
            cnt           <= '0;
            avg_q         <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
        end else begin
            // A held sample drains whenever downstream accepts, even while disabled.
            if (M_AXIS_tready)
                M_AXIS_tvalid <= 1'b0;

            if (!demod_enable) begin
                state <= PRIME;
                acc   <= '0;
                cnt   <= '0;
            end else if (hs) begin
                prev <= S_AXIS_tdata;
                case (state)
                    PRIME: state <= RUN;
                    RUN: begin
                        if (cnt == '0)
                            avg_q <= log2_avg;
                        if (last) begin
                            // hs guarantees the output slot is free or draining this cycle.
                            acc           <= '0;
                            cnt           <= '0;
                            M_AXIS_tvalid <= 1'b1;
                            M_AXIS_tdata  <= gained;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= PRIME;
                endcase
            end
        end
    end

endmodule
